// File: rtl/alsu_stream_if.sv
// alsu_stream_if: command/result handshake bundle for alsu_stream.
// The master drives commands and result acceptance; the slave is the ALSU.
interface alsu_stream_if #(
  parameter int WIDTH = 3,
  parameter int LED_W = 16
);
  localparam int OW = 2 * WIDTH;
  localparam int SW = $clog2(OW);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             red_op_A;
  logic             red_op_B;
  logic             bypass_A;
  logic             bypass_B;
  logic             direction;
  logic             serial_in;
  logic [SW-1:0]    shamt;
  logic             out_valid;
  logic             out_ready;
  logic [OW-1:0]    out;
  logic             err;
  logic [LED_W-1:0] leds;

  modport master (
    output in_valid, opcode, A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B,
           direction, serial_in, shamt, out_ready,
    input  in_ready, out_valid, out, err, leds
  );

  modport slave (
    input  in_valid, opcode, A, B, cin, red_op_A, red_op_B, bypass_A, bypass_B,
           direction, serial_in, shamt, out_ready,
    output in_ready, out_valid, out, err, leds
  );
endinterface

// File: rtl/alsu_stream.sv
// alsu_stream: handshaked ALSU (bypass, reduction, add, multiply, shift/rotate of the last result).
// Define ALSU_SEQ_MULT_EN to compute MUL with an iterative WIDTH-cycle shift-add sequencer.
module alsu_stream #(
  parameter int    WIDTH          = 3,
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON",
  parameter int    LED_W          = 16
) (
  input logic          clk,
  input logic          rst,
  alsu_stream_if.slave bus
);
  localparam int OW = 2 * WIDTH;
  localparam int SW = $clog2(OW);
  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit ADD_CIN = (FULL_ADDER == "ON");
  localparam logic [OW-1:0] ONES = '1;
  localparam logic [SW:0]   OW_W = (SW+1)'(OW);

  localparam logic [2:0] OP_OR    = 3'd0;
  localparam logic [2:0] OP_XOR   = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_SHIFT = 3'd4;
  localparam logic [2:0] OP_ROT   = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_MUL, S_DONE} state_t;
  state_t state;

  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             cin_q, red_a_q, red_b_q, byp_a_q, byp_b_q, dir_q, ser_q;
  logic [SW-1:0]    shamt_q;
  logic [OW-1:0]    out_q;
  logic             err_q;
  logic [LED_W-1:0] leds_q;

  logic [OW-1:0] ext_a, ext_b, calc_res, shift_res, rot_res, shl_fill, shr_fill;
  logic [SW:0]   rot_amt, rot_comp;
  logic          invalid, byp_any, calc_err;

  assign ext_a   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
  assign ext_b   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
  assign byp_any = byp_a_q | byp_b_q;
  assign invalid = ((red_a_q | red_b_q) && (op_q != OP_OR) && (op_q != OP_XOR))
                   || (op_q > OP_ROT);
  assign calc_err = invalid && !byp_any;

  // Shifts past the register width leave only fill bits, which the masks give for free.
  assign shl_fill  = ser_q ? ~(ONES << shamt_q) : '0;
  assign shr_fill  = ser_q ? ~(ONES >> shamt_q) : '0;
  assign shift_res = dir_q ? ((out_q << shamt_q) | shl_fill)
                           : ((out_q >> shamt_q) | shr_fill);
  assign rot_amt   = {1'b0, shamt_q} % OW_W;
  assign rot_comp  = OW_W - rot_amt;
  assign rot_res   = dir_q ? ((out_q << rot_amt) | (out_q >> rot_comp))
                           : ((out_q >> rot_amt) | (out_q << rot_comp));

  always_comb begin
    calc_res = '0;
    if (byp_a_q && byp_b_q) begin
      calc_res = PRIO_A ? ext_a : ext_b;
    end else if (byp_a_q) begin
      calc_res = ext_a;
    end else if (byp_b_q) begin
      calc_res = ext_b;
    end else if (!invalid) begin
      case (op_q)
        OP_OR: begin
          if (red_a_q && red_b_q) calc_res[0] = PRIO_A ? (|a_q) : (|b_q);
          else if (red_a_q)       calc_res[0] = |a_q;
          else if (red_b_q)       calc_res[0] = |b_q;
          else                    calc_res = {{WIDTH{1'b0}}, a_q | b_q};
        end
        OP_XOR: begin
          if (red_a_q && red_b_q) calc_res[0] = PRIO_A ? (^a_q) : (^b_q);
          else if (red_a_q)       calc_res[0] = ^a_q;
          else if (red_b_q)       calc_res[0] = ^b_q;
          else                    calc_res = {{WIDTH{1'b0}}, a_q ^ b_q};
        end
        OP_ADD:   calc_res = ext_a + ext_b + {{(OW-1){1'b0}}, cin_q & ADD_CIN};
        OP_MUL:   calc_res = ext_a * ext_b;
        OP_SHIFT: calc_res = shift_res;
        OP_ROT:   calc_res = rot_res;
        default:  calc_res = '0;
      endcase
    end
  end

`ifdef ALSU_SEQ_MULT_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    cnt;
  logic [OW-1:0]    mag_a_sh, acc, acc_next, a_mag, prod_final;
  logic [WIDTH-1:0] mag_b, b_mag;
  logic             neg_q;

  // Magnitudes are multiplied unsigned and the sign is reapplied on the final step.
  assign a_mag      = a_q[WIDTH-1] ? (~ext_a + OW'(1)) : ext_a;
  assign b_mag      = b_q[WIDTH-1] ? (~b_q + WIDTH'(1)) : b_q;
  assign acc_next   = acc + (mag_b[0] ? mag_a_sh : '0);
  assign prod_final = neg_q ? (~acc_next + OW'(1)) : acc_next;
`endif

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.out       = out_q;
  assign bus.err       = err_q;
  assign bus.leds      = leds_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      red_a_q <= 1'b0;
      red_b_q <= 1'b0;
      byp_a_q <= 1'b0;
      byp_b_q <= 1'b0;
      dir_q   <= 1'b0;
      ser_q   <= 1'b0;
      shamt_q <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      leds_q  <= '0;
`ifdef ALSU_SEQ_MULT_EN
      cnt      <= '0;
      mag_a_sh <= '0;
      mag_b    <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q    <= bus.opcode;
            a_q     <= bus.A;
            b_q     <= bus.B;
            cin_q   <= bus.cin;
            red_a_q <= bus.red_op_A;
            red_b_q <= bus.red_op_B;
            byp_a_q <= bus.bypass_A;
            byp_b_q <= bus.bypass_B;
            dir_q   <= bus.direction;
            ser_q   <= bus.serial_in;
            shamt_q <= bus.shamt;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
`ifdef ALSU_SEQ_MULT_EN
          if (!byp_any && !invalid && op_q == OP_MUL) begin
            cnt      <= CW'(WIDTH);
            acc      <= '0;
            mag_a_sh <= a_mag;
            mag_b    <= b_mag;
            neg_q    <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
            state    <= S_MUL;
          end else
`endif
          begin
            out_q  <= calc_res;
            err_q  <= calc_err;
            leds_q <= calc_err ? ~leds_q : '0;
            state  <= S_DONE;
          end
        end
        S_MUL: begin
`ifdef ALSU_SEQ_MULT_EN
          cnt      <= cnt - CW'(1);
          acc      <= acc_next;
          mag_a_sh <= mag_a_sh << 1;
          mag_b    <= mag_b >> 1;
          if (cnt == CW'(1)) begin
            out_q  <= prod_final;
            err_q  <= 1'b0;
            leds_q <= '0;
            state  <= S_DONE;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
          else if (err_q)    leds_q <= ~leds_q;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alsu_stream.sv
// tb_alsu_stream: directed literal cases plus randomized traffic against a behavioural model.
// Honours ALSU_SEQ_MULT_EN for the expected MUL latency.
module tb_alsu_stream;
  localparam int WIDTH = 3;
  localparam int OW    = 2 * WIDTH;
  localparam int SW    = $clog2(OW);
  localparam int LED_W = 16;
`ifdef ALSU_SEQ_MULT_EN
  localparam int MUL_LAT = 2 + WIDTH;
`else
  localparam int MUL_LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alsu_stream_if #(.WIDTH(WIDTH), .LED_W(LED_W)) bus ();

  alsu_stream #(
    .WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LED_W)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int sval(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? int'(v) - (1 << WIDTH) : int'(v);
  endfunction

  // Reference result from the arithmetic meaning of the command, using the last result as shift source.
  function automatic void ref_calc(input logic [OW-1:0] prev, output logic [OW-1:0] res,
                                   output bit e, output int lat);
    int a, b, src, amt;
    a = sval(bus.A);
    b = sval(bus.B);
    e = 1'b0;
    lat = 2;
    res = '0;
    if (bus.bypass_A || bus.bypass_B) begin
      res = bus.bypass_A ? OW'(a) : OW'(b);
    end else if (bus.opcode > 3'd5 || ((bus.red_op_A || bus.red_op_B) && bus.opcode > 3'd1)) begin
      e = 1'b1;
    end else begin
      case (bus.opcode)
        3'd0, 3'd1: begin
          if (bus.red_op_A || bus.red_op_B) begin
            src = bus.red_op_A ? $countones(bus.A) : $countones(bus.B);
            res = (bus.opcode == 3'd0) ? OW'(src != 0) : OW'(src % 2);
          end else begin
            res = (bus.opcode == 3'd0) ? OW'(bus.A | bus.B) : OW'(bus.A ^ bus.B);
          end
        end
        3'd2: res = OW'(a + b + int'(bus.cin));
        3'd3: begin res = OW'(a * b); lat = MUL_LAT; end
        3'd4: for (int i = 0; i < OW; i++) begin
          src = bus.direction ? i - int'(bus.shamt) : i + int'(bus.shamt);
          res[i] = (src >= 0 && src < OW) ? prev[SW'(src)] : bus.serial_in;
        end
        default: begin
          amt = int'(bus.shamt) % OW;
          for (int i = 0; i < OW; i++) begin
            src = bus.direction ? (i - amt + OW) % OW : (i + amt) % OW;
            res[i] = prev[SW'(src)];
          end
        end
      endcase
    end
  endfunction

  logic [OW-1:0]    m_out = '0;
  logic [OW-1:0]    m_pend_out = '0;
  logic [LED_W-1:0] m_leds = '0;
  bit m_err = 1'b0, m_pend_err = 1'b0, m_idle = 1'b1, m_valid = 1'b0;
  int m_wait = 0;
  int m_lat = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0;
      m_out = '0; m_err = 1'b0; m_leds = '0;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid = 1'b0;
        m_idle = 1'b1;
      end else if (m_err) begin
        m_leds = ~m_leds;
      end
    end else if (!m_idle) begin
      m_wait--;
      if (m_wait == 0) begin
        m_valid = 1'b1;
        m_out = m_pend_out;
        m_err = m_pend_err;
        m_leds = m_err ? ~m_leds : '0;
      end
    end else if (bus.in_valid) begin
      ref_calc(m_out, m_pend_out, m_pend_err, m_lat);
      m_wait = m_lat - 1;
      m_idle = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("in_ready",  bus.in_ready,  m_idle);
      checkOutput("out_valid", bus.out_valid, m_valid);
      checkOutput("out",       bus.out,       m_out);
      checkOutput("err",       bus.err,       m_err);
      checkOutput("leds",      bus.leds,      m_leds);
    end
  end

  // Presents one command for a single edge; must be called at a negedge while idle.
  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input bit c, input bit ra, input bit rb, input bit ba, input bit bb,
                               input bit dir, input bit ser, input logic [SW-1:0] sh);
    bus.opcode = op; bus.A = a; bus.B = b; bus.cin = c;
    bus.red_op_A = ra; bus.red_op_B = rb; bus.bypass_A = ba; bus.bypass_B = bb;
    bus.direction = dir; bus.serial_in = ser; bus.shamt = sh;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitResult(input int exp_lat, input string name);
    int n = 1;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " latency"}, n, exp_lat);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.opcode = '0; bus.A = '0; bus.B = '0;
    bus.cin = 1'b0; bus.red_op_A = 1'b0; bus.red_op_B = 1'b0; bus.bypass_A = 1'b0;
    bus.bypass_B = 1'b0; bus.direction = 1'b0; bus.serial_in = 1'b0; bus.shamt = '0;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset out", bus.out, 6'b000000);
    checkOutput("reset out_valid", bus.out_valid, 1'b0);
    checkOutput("reset leds", bus.leds, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle in_ready", bus.in_ready, 1'b1);

    applyStimulus(3'd2, 3'd3, 3'b110, 1'b1, 0, 0, 0, 0, 0, 0, '0);
    waitResult(2, "add");
    checkOutput("add out", bus.out, 6'b000010);
    checkOutput("add err", bus.err, 1'b0);
    @(negedge clk);

    applyStimulus(3'd3, 3'b100, 3'd3, 1'b0, 0, 0, 0, 0, 0, 0, '0);
    waitResult(MUL_LAT, "mul");
    checkOutput("mul out", bus.out, 6'b110100);
    @(negedge clk);

    applyStimulus(3'd0, 3'b101, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0, '0);
    waitResult(2, "or");
    checkOutput("or out", bus.out, 6'b000101);
    @(negedge clk);

    applyStimulus(3'd4, 3'd0, 3'd0, 1'b0, 0, 0, 0, 0, 1, 1, SW'(2));
    waitResult(2, "shift");
    checkOutput("shift out", bus.out, 6'b010111);
    @(negedge clk);

    applyStimulus(3'd5, 3'd0, 3'd0, 1'b0, 0, 0, 0, 0, 0, 0, SW'(1));
    waitResult(2, "rotate");
    checkOutput("rotate out", bus.out, 6'b101011);
    @(negedge clk);

    bus.out_ready = 1'b0;
    applyStimulus(3'd6, 3'd1, 3'd2, 1'b0, 0, 0, 0, 0, 0, 0, '0);
    waitResult(2, "invalid");
    checkOutput("invalid out", bus.out, 6'b000000);
    checkOutput("invalid err", bus.err, 1'b1);
    checkOutput("invalid leds 1", bus.leds, 16'hFFFF);
    @(negedge clk);
    checkOutput("invalid leds 2", bus.leds, 16'h0000);
    @(negedge clk);
    checkOutput("invalid leds 3", bus.leds, 16'hFFFF);
    checkOutput("invalid held err", bus.err, 1'b1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("after invalid in_ready", bus.in_ready, 1'b1);

    applyStimulus(3'd0, 3'b001, 3'b010, 1'b0, 0, 0, 0, 0, 0, 0, '0);
    waitResult(2, "or after invalid");
    checkOutput("or leds cleared", bus.leds, 16'h0000);
    checkOutput("or after invalid out", bus.out, 6'b000011);
    @(negedge clk);

    applyStimulus(3'd2, 3'b111, 3'b010, 1'b0, 1, 0, 1, 1, 0, 0, '0);
    waitResult(2, "bypass");
    checkOutput("bypass out", bus.out, 6'b111111);
    checkOutput("bypass err", bus.err, 1'b0);
    @(negedge clk);

    applyStimulus(3'd3, 3'b011, 3'b010, 1'b0, 0, 0, 0, 0, 0, 0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid reset out", bus.out, 6'b000000);
    checkOutput("mid reset out_valid", bus.out_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post reset in_ready", bus.in_ready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no stale result", bus.out_valid, 1'b0);
    end

    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst           = ($urandom_range(0, 299) == 0);
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.opcode    = 3'($urandom_range(0, 7));
      bus.A         = WIDTH'($urandom);
      bus.B         = WIDTH'($urandom);
      bus.cin       = 1'($urandom);
      bus.red_op_A  = ($urandom_range(0, 5) == 0);
      bus.red_op_B  = ($urandom_range(0, 5) == 0);
      bus.bypass_A  = ($urandom_range(0, 7) == 0);
      bus.bypass_B  = ($urandom_range(0, 7) == 0);
      bus.direction = 1'($urandom);
      bus.serial_in = 1'($urandom);
      bus.shamt     = SW'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
